laser_rx_deframer: RTL and testbench
====================================

Name: laser_rx_deframer

Overview:
Receive-side deframer for one laser lane. It samples the photodiode GPIO input, detects and validates a start bit, and deserializes a 16-bit payload into two bytes with parity and stop-bit checking. Each good frame produces a one-cycle data_valid strobe. It sits between the raw GPIO receive pin and the chip-level logic that consumes data1_in/data2_in/data_valid.

Parameters:
CLKS_PER_BIT, 8, clock cycles per line bit; must be even and >= 4
ERR_CNT_W, 8, width of the saturating frame-error counter

Ports:
clock  input  1  system clock (CLOCK_50 domain)
resetN  input  1  asynchronous active-low reset
enable  input  1  receiver enable; when low, the FSM is held in IDLE
rx  input  1  raw laser receive line, asynchronous; idle low (laser off)
data1  output  8  first payload byte of the last good frame
data2  output  8  second payload byte of the last good frame
data_valid  output  1  one-cycle pulse when a good frame completes
frame_err  output  1  one-cycle pulse on a parity or stop error
busy  output  1  high in any state other than IDLE
err_count  output  ERR_CNT_W  saturating count of frame_err pulses

Behaviour:
- Frame format on the line: start bit (1), then 16 data bits LSB-first (data1[0..7], then data2[0..7]), then an even-parity bit (total ones over data and parity is even), then a stop bit (0).
- rx passes through a 2-FF synchronizer; all logic uses the synchronized value rx_s.
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous; asserting it mid-frame aborts the frame with no data_valid and no frame_err.
- FSM states: IDLE, START, DATA, PARITY, STOP, RECOVER.
- IDLE: on rx_s==1 and enable, go to START and clear the sample counter.
- START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 1, go to DATA with bit_cnt=0. If 0, treat it as a glitch and return to IDLE silently.
- DATA: sample every CLKS_PER_BIT cycles and shift into a 16-bit shift register. After bit 15, go to PARITY.
- PARITY: sample once and store the bit. Go to STOP.
- STOP: sample once.
  - Stop==0 and parity good: load data1/data2 from the shift register, pulse data_valid the next cycle, go to IDLE.
  - Parity bad and stop==0: pulse frame_err, leave data1/data2 unchanged, go to IDLE.
  - Stop==1: pulse frame_err, go to RECOVER. Stop==1 takes precedence when both errors are present; that case produces one pulse.
- RECOVER: wait for CLKS_PER_BIT consecutive rx_s==0 cycles, then go to IDLE.
- Latency: let N0 be the first edge at which raw rx is captured high. The stop sample occurs at N0+2+CLKS_PER_BIT/2+18*CLKS_PER_BIT. data_valid is high in the following cycle (N0+151 for the default). data1/data2 update in the same cycle as data_valid and hold until the next good frame.
- enable deasserted mid-frame: the frame completes normally. enable gates only the IDLE->START transition.
- err_count increments on each frame_err and saturates at all-ones (no wrap).
- data_valid and frame_err are never high in the same cycle.
- Back-to-back frames: a start bit arriving 1 cycle after the stop sample is accepted, because IDLE is re-entered on the cycle of data_valid.

Decomposition:
- Package laser_rx_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, RECOVER)
  - FRAME_DATA_BITS=16
  - PARITY_EVEN=1'b1 constant
  - function for even parity of a 16-bit word
- Sub-module sync_2ff (1-bit, async active-low reset to 0), instantiated once for rx.
- Sample counter width is $clog2(CLKS_PER_BIT).

Test Plan:
- Good frame: send data1=8'hA5, data2=8'h3C, parity 0, stop 0 at CLKS_PER_BIT=8. Expect data_valid high exactly at N0+151, data1=A5, data2=3C, frame_err=0, err_count=0.
- Bad parity: same payload with parity 1. Expect frame_err pulse, no data_valid, data1/data2 keep their previous values, err_count=1.
- Bad stop: payload 8'h01/8'h00, parity 1, stop held 1 for 3 bit-times. Expect one frame_err and busy high until 8 cycles after rx returns low, then IDLE. Follow with a good frame 16'hBEEF, which is received correctly.
- Glitch rejection: rx pulsed high for 2 cycles. Expect no data_valid, no frame_err, and busy drops within 6 cycles.
- Reset mid-frame: assert resetN low during data bit 7 for 1 cycle. Expect all outputs 0 immediately; a subsequent frame 8'h12/8'h34 is received correctly.
- Back-to-back plus saturation:
  - Two good frames with zero gap (8'h00/8'hFF, then 8'hFF/8'h00) produce two data_valid pulses with correct data.
  - 260 bad-parity frames leave err_count at 255.

Source files
------------

// File: rtl/laser_rx_deframer_pkg.sv
// Shared types and constants for the laser lane receive deframer.
// Holds the FSM state encoding and the parity helper.
package laser_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        RECOVER
    } rx_state_t;

    localparam int   FRAME_DATA_BITS = 16;
    localparam logic PARITY_EVEN     = 1'b1;

    // Parity bit that makes the total number of ones over word and bit even.
    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/laser_rx_deframer_sync.sv
// Two-flop synchronizer bringing the asynchronous laser receive line into the clock domain.
module sync_2ff (
    input  logic i_clock,
    input  logic i_resetN,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/laser_rx_deframer.sv
// Laser lane deframer: start-bit validation, 16-bit LSB-first payload, even parity and
// stop-bit checking, with a saturating frame-error counter.
module laser_rx_deframer
    import laser_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 i_clock,
    input  logic                 i_resetN,
    input  logic                 i_enable,
    input  logic                 i_rx,
    output logic [7:0]           o_data1,
    output logic [7:0]           o_data2,
    output logic                 o_data_valid,
    output logic                 o_frame_err,
    output logic                 o_busy,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int                 BIT_CNT_W = $clog2(FRAME_DATA_BITS);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_DATA_BITS - 1);

    logic                       w_rx_s;
    logic                       w_parity_ok;
    logic                       w_err_sat;

    rx_state_t                  r_state;
    logic [CNT_W-1:0]           r_sample_cnt;
    logic [BIT_CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_DATA_BITS-1:0] r_shift;
    logic                       r_parity;
    logic [7:0]                 r_data1;
    logic [7:0]                 r_data2;
    logic                       r_data_valid;
    logic                       r_frame_err;
    logic [ERR_CNT_W-1:0]       r_err_count;

    sync_2ff u_rx_sync (
        .i_clock  (i_clock),
        .i_resetN (i_resetN),
        .i_d      (i_rx),
        .o_q      (w_rx_s)
    );

    assign w_parity_ok = (r_parity == (even_parity(r_shift) ^ ~PARITY_EVEN));
    assign w_err_sat   = &r_err_count;

    // Payload shifts in from the top so the first line bit ends up at bit 0.
    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_data1      <= '0;
            r_data2      <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rx_s && i_enable) begin
                        r_state      <= START;
                        r_sample_cnt <= '0;
                    end
                end
                START: begin
                    if (r_sample_cnt == HALF_LAST) begin
                        r_sample_cnt <= '0;
                        if (w_rx_s) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_sample_cnt == FULL_LAST) begin
                        r_sample_cnt <= '0;
                        r_shift      <= {w_rx_s, r_shift[FRAME_DATA_BITS-1:1]};
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (r_sample_cnt == FULL_LAST) begin
                        r_sample_cnt <= '0;
                        r_parity     <= w_rx_s;
                        r_state      <= STOP;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_sample_cnt == FULL_LAST) begin
                        r_sample_cnt <= '0;
                        // A high stop bit means the line is still lit; wait it out before rearming.
                        if (w_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_state     <= RECOVER;
                            if (!w_err_sat) r_err_count <= r_err_count + ERR_CNT_W'(1);
                        end else if (w_parity_ok) begin
                            r_data1      <= r_shift[7:0];
                            r_data2      <= r_shift[15:8];
                            r_data_valid <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= IDLE;
                            if (!w_err_sat) r_err_count <= r_err_count + ERR_CNT_W'(1);
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    end
                end
                RECOVER: begin
                    if (w_rx_s) begin
                        r_sample_cnt <= '0;
                    end else if (r_sample_cnt == FULL_LAST) begin
                        r_sample_cnt <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_data1      = r_data1;
    assign o_data2      = r_data2;
    assign o_data_valid = r_data_valid;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = (r_state != IDLE);
    assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_laser_rx_deframer.sv
// Scoreboard bench for laser_rx_deframer: frames are queued with hand-computed results
// and an independent monitor checks every data_valid / frame_err strobe.
module tb_laser_rx_deframer;

    localparam int CPB     = 8;
    localparam int EW      = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    typedef struct {
        bit         isErr;
        logic [7:0] d1;
        logic [7:0] d2;
        int         cnt;
        int         cyc;
    } exp_t;

    logic          clock  = 1'b0;
    logic          resetN = 1'b1;
    logic          enable = 1'b0;
    logic          rx     = 1'b0;
    logic [7:0]    data1;
    logic [7:0]    data2;
    logic          dataValid;
    logic          frameErr;
    logic          busy;
    logic [EW-1:0] errCount;

    int   cycle    = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   errModel = 0;
    exp_t expQ[$];

    laser_rx_deframer #(.CLKS_PER_BIT(CPB), .ERR_CNT_W(EW)) dut (
        .i_clock      (clock),
        .i_resetN     (resetN),
        .i_enable     (enable),
        .i_rx         (rx),
        .o_data1      (data1),
        .o_data2      (data2),
        .o_data_valid (dataValid),
        .o_frame_err  (frameErr),
        .o_busy       (busy),
        .o_err_count  (errCount)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_data1"}, data1, 0);
        checkOutput({tag, "_data2"}, data2, 0);
        checkOutput({tag, "_valid"}, dataValid, 0);
        checkOutput({tag, "_ferr"}, frameErr, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_errcnt"}, errCount, 0);
    endtask

    // Drives one frame starting at a negedge. kind: 0 none, 1 good, 2 frame error.
    // The strobe is consumed at edge N0+151, i.e. visible right after edge N0+150.
    task automatic applyStimulus(input logic [15:0] word, input logic par, input logic stopVal,
                                 input int stopBits, input int kind,
                                 input logic [7:0] expD1, input logic [7:0] expD2, input int abortBit);
        logic lineBits[0:20];
        int   nBits;
        int   n0;
        exp_t e;
        nBits = 18 + stopBits;
        lineBits[0] = 1'b1;
        for (int i = 0; i < 16; i++) lineBits[i+1] = word[i];
        lineBits[17] = par;
        for (int i = 0; i < stopBits; i++) lineBits[18+i] = stopVal;
        n0 = cycle + 1;
        if (kind != 0) begin
            if (kind == 2 && errModel < ERR_MAX) errModel++;
            e.isErr = (kind == 2);
            e.d1    = expD1;
            e.d2    = expD2;
            e.cnt   = errModel;
            e.cyc   = n0 + 150;
            expQ.push_back(e);
        end
        for (int b = 0; b < nBits; b++) begin
            rx = lineBits[b];
            if (b == abortBit) begin
                repeat (4) @(negedge clock);
                #2 resetN = 1'b0;
                #1 checkResetOutputs("midreset");
                @(negedge clock);
                resetN   = 1'b1;
                rx       = 1'b0;
                errModel = 0;
                return;
            end
            repeat (CPB) @(negedge clock);
        end
        rx = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resetN && (dataValid || frameErr)) begin
            checkOutput("valid_err_exclusive", dataValid & frameErr, 0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_event", {dataValid, frameErr}, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("event_is_err", frameErr, e.isErr);
                checkOutput("event_cycle", cycle, e.cyc);
                checkOutput("event_data1", data1, e.d1);
                checkOutput("event_data2", data2, e.d2);
                checkOutput("event_errcnt", errCount, e.cnt);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog actual=cycle_%0d expected=finished", cycle);
        $fatal(1, "[TB] watchdog timeout");
    end

    initial begin
        int k;
        #1 resetN = 1'b0;
        #2 checkResetOutputs("reset");
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        enable = 1'b1;
        repeat (4) @(negedge clock);

        $display("[TB] good frame A5/3C");
        applyStimulus(16'h3CA5, 1'b0, 1'b0, 1, 1, 8'hA5, 8'h3C, -1);

        $display("[TB] bad parity A5/3C");
        applyStimulus(16'h3CA5, 1'b1, 1'b0, 1, 2, 8'hA5, 8'h3C, -1);

        $display("[TB] bad stop 01/00 held high three bit-times");
        applyStimulus(16'h0001, 1'b1, 1'b1, 3, 2, 8'hA5, 8'h3C, -1);
        checkOutput("recover_busy_at_release", busy, 1);
        repeat (8) @(negedge clock);
        checkOutput("recover_busy_hold", busy, 1);
        repeat (4) @(negedge clock);
        checkOutput("recover_busy_done", busy, 0);

        $display("[TB] good frame BEEF after recovery");
        applyStimulus(16'hBEEF, 1'b1, 1'b0, 1, 1, 8'hEF, 8'hBE, -1);

        $display("[TB] glitch rejection");
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (2) @(negedge clock);
        rx = 1'b0;
        @(negedge clock);
        checkOutput("glitch_busy_start", busy, 1);
        repeat (5) @(negedge clock);
        checkOutput("glitch_busy_drop", busy, 0);
        repeat (4) @(negedge clock);

        $display("[TB] enable gating");
        enable = 1'b0;
        rx     = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("disabled_busy", busy, 0);
        rx = 1'b0;
        repeat (5) @(negedge clock);
        enable = 1'b1;
        repeat (5) @(negedge clock);
        fork
            applyStimulus(16'hF00F, 1'b0, 1'b0, 1, 1, 8'h0F, 8'hF0, -1);
            begin
                repeat (40) @(negedge clock);
                enable = 1'b0;
            end
        join
        enable = 1'b1;
        repeat (4) @(negedge clock);

        $display("[TB] reset during data bit 7");
        applyStimulus(16'h5555, 1'b0, 1'b0, 1, 0, 8'h00, 8'h00, 8);
        repeat (12) @(negedge clock);
        checkOutput("post_reset_busy", busy, 0);
        applyStimulus(16'h3412, 1'b1, 1'b0, 1, 1, 8'h12, 8'h34, -1);

        $display("[TB] back-to-back frames");
        applyStimulus(16'hFF00, 1'b0, 1'b0, 1, 1, 8'h00, 8'hFF, -1);
        applyStimulus(16'h00FF, 1'b0, 1'b0, 1, 1, 8'hFF, 8'h00, -1);

        $display("[TB] error counter saturation");
        for (int i = 0; i < 260; i++) begin
            applyStimulus(16'h0000, 1'b1, 1'b0, 1, 2, 8'hFF, 8'h00, -1);
        end

        k = 0;
        while (expQ.size() != 0 && k < 400) begin
            @(negedge clock);
            k++;
        end
        checkOutput("scoreboard_drained", expQ.size(), 0);
        repeat (4) @(negedge clock);
        checkOutput("final_errcnt_saturated", errCount, ERR_MAX);
        checkOutput("final_data1_held", data1, 8'hFF);
        checkOutput("final_data2_held", data2, 8'h00);
        checkOutput("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
